// File: rtl/fifo_umbrales_if.sv
// FIFO bus for fifo_umbrales: write/read handshake, threshold loading and the
// occupancy/status flags. The master drives requests; the FIFO is the slave.
interface fifo_umbrales_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              umbral_load;
  logic [2:0]        bajo;
  logic [2:0]        alto;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              error;

  modport master (
    output push, data_in, pop, umbral_load, bajo, alto,
    input  data_out, valid_out, empty, full, almost_empty, almost_full, count, error
  );

  modport slave (
    input  push, data_in, pop, umbral_load, bajo, alto,
    output data_out, valid_out, empty, full, almost_empty, almost_full, count, error
  );
endinterface

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: 2**ADDR_W-entry circular FIFO with registered read data and
// programmable almost-empty / almost-full thresholds.
// Build option FIFO_ERROR_STICKY_EN: when defined, error latches on the first
// overflow/underflow until reset; otherwise it pulses for one cycle after each
// rejected operation.
module fifo_umbrales #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input  logic clk,
  input  logic reset,
  fifo_umbrales_if.slave bus
);

  localparam int              DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] C_FULL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_error;
  logic [2:0]        r_bajo_q;
  logic [2:0]        r_alto_q;

  logic              w_empty;
  logic              w_full;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic              w_err_evt;
  logic [ADDR_W:0]   w_alto_eff;

  // Status and acceptance decode from the registered occupancy.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_FULL);
  // A pop only succeeds on a non-empty FIFO, so push+pop on empty never
  // bypasses: the push is stored and the pop is flagged as an underflow.
  assign w_pop_ok   = bus.pop && !w_empty;
  // When full, a push is still taken if a pop frees the slot in the same cycle.
  assign w_push_ok  = bus.push && (!w_full || w_pop_ok);
  assign w_err_evt  = (bus.push && !w_push_ok) || (bus.pop && !w_pop_ok);
  // An almost-full threshold of 0 means "only when completely full".
  assign w_alto_eff = (r_alto_q == 3'd0) ? C_FULL : (ADDR_W + 1)'(r_alto_q);

  // Storage write; the slot at wr_ptr is overwritten on an accepted push.
  // NOTE: the memory has no reset on purpose -- stale contents are unreachable
  // once the pointers and count are cleared, and a reset here would stop the
  // array from mapping onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy and registered read port.
  // NOTE: non-blocking assignments make a same-cycle push+pop on a full FIFO
  // read the old entry at rd_ptr before the push overwrites that slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Threshold registers, reloaded whenever umbral_load is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bajo_q <= '0;
      r_alto_q <= '0;
    end else if (bus.umbral_load) begin
      r_bajo_q <= bus.bajo;
      r_alto_q <= bus.alto;
    end
  end

  // Overflow/underflow flag: latched or one-cycle pulse depending on build.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else begin
`ifdef FIFO_ERROR_STICKY_EN
      r_error <= r_error | w_err_evt;
`else
      r_error <= w_err_evt;
`endif
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  // Overlapping thresholds are legal; both flags may be high together.
  assign bus.almost_empty = (r_count <= (ADDR_W + 1)'(r_bajo_q));
  assign bus.almost_full  = (r_count >= w_alto_eff);
  assign bus.error        = r_error;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed self-checking bench for fifo_umbrales (default depth 8, width 6).
// Follows FIFO_ERROR_STICKY_EN for the expected error behaviour.
module tb_fifo_umbrales;

`ifdef FIFO_ERROR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fifo_umbrales_if #(.DATA_W(6), .ADDR_W(3)) bus ();

  fifo_umbrales #(.DATA_W(6), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push = 1'b0; bus.pop = 1'b0; bus.umbral_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.data_in = '0; bus.bajo = '0; bus.alto = '0;
    idle();

    // Reset state.
    do_reset();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_aempty", bus.almost_empty, 1);
    check("rst_afull", bus.almost_full, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_error", bus.error, 0);
    check("rst_dout", bus.data_out, 0);

    // Thresholds bajo=1 alto=6, then fill with 0x01..0x08.
    bus.umbral_load = 1'b1; bus.bajo = 3'd1; bus.alto = 3'd6;
    step();
    idle();
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.data_in = 6'(i);
      step();
      check("fill_count", bus.count, i);
      check("fill_afull", bus.almost_full, (i >= 6));
      check("fill_aempty", bus.almost_empty, (i <= 1));
      check("fill_full", bus.full, (i == 8));
      check("fill_error", bus.error, 0);
    end

    // Overflow: push 0x3F while full.
    bus.push = 1'b1; bus.data_in = 6'h3F;
    step();
    idle();
    check("ovf_error", bus.error, 1);
    check("ovf_count", bus.count, 8);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      bus.pop = 1'b1;
      step();
      check("drain_valid", bus.valid_out, 1);
      check("drain_data", bus.data_out, i);
      check("drain_count", bus.count, 8 - i);
      check("drain_error", bus.error, STICKY);
    end
    idle();
    step();
    check("drain_valid_end", bus.valid_out, 0);
    check("drain_empty", bus.empty, 1);

    // Wrap: refill with 0x11..0x18, then push 0x2A with pop while full.
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.data_in = 6'(16 + i);
      step();
    end
    check("refill_full", bus.full, 1);
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 6'h2A;
    step();
    idle();
    check("pp_count", bus.count, 8);
    check("pp_valid", bus.valid_out, 1);
    check("pp_data", bus.data_out, 6'h11);
    check("pp_error", bus.error, STICKY);
    for (int i = 2; i <= 9; i++) begin
      bus.pop = 1'b1;
      step();
      check("wrap_data", bus.data_out, (i == 9) ? 6'h2A : 6'(16 + i));
    end
    idle();
    step();
    check("wrap_empty", bus.empty, 1);

    // Underflow from a clean reset; data_out must hold.
    do_reset();
    bus.pop = 1'b1;
    step();
    idle();
    check("unf_valid", bus.valid_out, 0);
    check("unf_error", bus.error, 1);
    check("unf_dout", bus.data_out, 0);
    check("unf_count", bus.count, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("unf_hold", bus.error, STICKY);
    end

    // Push+pop on empty: push stored, pop is an underflow.
    do_reset();
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 6'h05;
    step();
    idle();
    check("pe_count", bus.count, 1);
    check("pe_valid", bus.valid_out, 0);
    check("pe_error", bus.error, 1);
    bus.pop = 1'b1;
    step();
    idle();
    check("pe_data", bus.data_out, 6'h05);
    check("pe_dvalid", bus.valid_out, 1);

    // Threshold reload at count=3: bajo=4 takes effect one cycle later.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.push = 1'b1; bus.data_in = 6'(32 + i);
      step();
    end
    idle();
    bus.umbral_load = 1'b1; bus.bajo = 3'd4; bus.alto = 3'd0;
    #1;
    check("thr_ae_now", bus.almost_empty, 0);
    step();
    idle();
    check("thr_ae_next", bus.almost_empty, 1);
    check("thr_af_c3", bus.almost_full, 0);
    for (int i = 4; i <= 8; i++) begin
      bus.push = 1'b1; bus.data_in = 6'(32 + i);
      step();
      check("thr_af", bus.almost_full, (i == 8));
      check("thr_ae", bus.almost_empty, (i <= 4));
    end
    idle();

    // Reset at count=5 with push and umbral_load pending.
    for (int i = 0; i < 3; i++) begin
      bus.pop = 1'b1;
      step();
    end
    idle();
    check("pre_rst_count", bus.count, 5);
    reset = 1'b1; bus.push = 1'b1; bus.data_in = 6'h15;
    bus.umbral_load = 1'b1; bus.bajo = 3'd7; bus.alto = 3'd7;
    step();
    reset = 1'b0;
    idle();
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_valid", bus.valid_out, 0);
    check("mid_rst_error", bus.error, 0);
    check("mid_rst_afull", bus.almost_full, 0);
    bus.pop = 1'b1;
    step();
    idle();
    check("post_rst_unf_valid", bus.valid_out, 0);
    check("post_rst_unf_error", bus.error, 1);
    bus.push = 1'b1; bus.data_in = 6'h01;
    step();
    idle();
    check("post_rst_ae", bus.almost_empty, 0);
    check("post_rst_af", bus.almost_full, 0);
    check("post_rst_count", bus.count, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
